// File: rtl/fpnew_special_encoder.sv
// fpnew_special_encoder
//   Builds the FP bit pattern for a requested value class (zero, min
//   subnormal, min/max normal, inf, qNaN, sNaN) plus sign. It also emits the
//   matching fp_info_t, and pipelines the result behind a valid/ready handshake.
//   Optional feature macro: FPNEW_SPECIAL_ENC_BOX_EN
//     defined   -> bits above the format width are all ones (NaN-boxed)
//     undefined -> bits above the format width are all zeros

package fpnew_pkg;

    typedef enum logic [2:0] {
        FP32    = 3'd0,
        FP64    = 3'd1,
        FP16    = 3'd2,
        FP8     = 3'd3,
        FP16ALT = 3'd4
    } fp_format_e;

    typedef struct packed {
        logic is_normal;
        logic is_subnormal;
        logic is_zero;
        logic is_inf;
        logic is_nan;
        logic is_signalling;
        logic is_quiet;
        logic is_boxed;
    } fp_info_t;

    function automatic int unsigned exp_bits(fp_format_e fmt);
        case (fmt)
            FP64:    return 11;
            FP16:    return 5;
            FP8:     return 5;
            FP16ALT: return 8;
            default: return 8;
        endcase
    endfunction

    function automatic int unsigned man_bits(fp_format_e fmt);
        case (fmt)
            FP64:    return 52;
            FP16:    return 10;
            FP8:     return 2;
            FP16ALT: return 7;
            default: return 23;
        endcase
    endfunction

    function automatic int unsigned fp_width(fp_format_e fmt);
        return 1 + exp_bits(fmt) + man_bits(fmt);
    endfunction

endpackage

module fpnew_special_encoder #(
    parameter fpnew_pkg::fp_format_e FpFormat    = fpnew_pkg::FP32,
    parameter int unsigned           FLEN        = 64,
    parameter int unsigned           NumPipeRegs = 1,
    parameter int unsigned           TagWidth    = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    flush_i,
    input  logic [2:0]              class_i,
    input  logic                    sign_i,
    input  logic [TagWidth-1:0]     tag_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    output logic [FLEN-1:0]         result_o,
    output fpnew_pkg::fp_info_t     info_o,
    output logic                    invalid_o,
    output logic [TagWidth-1:0]     tag_o,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic                    busy_o
);

    localparam int unsigned WIDTH    = fpnew_pkg::fp_width(FpFormat);
    localparam int unsigned EXP_BITS = fpnew_pkg::exp_bits(FpFormat);
    localparam int unsigned MAN_BITS = fpnew_pkg::man_bits(FpFormat);

`ifdef FPNEW_SPECIAL_ENC_BOX_EN
    localparam logic BOX_BIT = 1'b1;
`else
    localparam logic BOX_BIT = 1'b0;
`endif

    localparam logic [2:0] CLS_ZERO    = 3'd0;
    localparam logic [2:0] CLS_SUBMIN  = 3'd1;
    localparam logic [2:0] CLS_NORMMIN = 3'd2;
    localparam logic [2:0] CLS_NORMMAX = 3'd3;
    localparam logic [2:0] CLS_INF     = 3'd4;
    localparam logic [2:0] CLS_QNAN    = 3'd5;
    localparam logic [2:0] CLS_SNAN    = 3'd6;

    localparam logic [EXP_BITS-1:0] EXP_ONES    = '1;
    localparam logic [EXP_BITS-1:0] EXP_MAXNORM = {{(EXP_BITS-1){1'b1}}, 1'b0};
    localparam logic [MAN_BITS-1:0] MAN_QUIET   = {1'b1, {(MAN_BITS-1){1'b0}}};
    localparam logic [MAN_BITS-1:0] MAN_ONE     = MAN_BITS'(1);

    logic                  enc_sign;
    logic [EXP_BITS-1:0]   enc_exp;
    logic [MAN_BITS-1:0]   enc_man;
    logic [FLEN-1:0]       enc_result;
    fpnew_pkg::fp_info_t   enc_info;
    logic                  enc_invalid;

    // Map the requested class onto sign/exponent/mantissa and its classification.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case leaves a variable unassigned and no latch is inferred.
        enc_sign          = sign_i;
        enc_exp           = '0;
        enc_man           = '0;
        enc_info          = '0;
        enc_info.is_boxed = 1'b1;
        enc_invalid       = 1'b0;
        case (class_i)
            CLS_ZERO: begin
                enc_info.is_zero = 1'b1;
            end
            CLS_SUBMIN: begin
                enc_man               = MAN_ONE;
                enc_info.is_subnormal = 1'b1;
            end
            CLS_NORMMIN: begin
                enc_exp            = EXP_BITS'(1);
                enc_info.is_normal = 1'b1;
            end
            CLS_NORMMAX: begin
                enc_exp            = EXP_MAXNORM;
                enc_man            = '1;
                enc_info.is_normal = 1'b1;
            end
            CLS_INF: begin
                enc_exp         = EXP_ONES;
                enc_info.is_inf = 1'b1;
            end
            CLS_SNAN: begin
                enc_sign               = 1'b0;
                enc_exp                = EXP_ONES;
                enc_man                = MAN_ONE;
                enc_info.is_nan        = 1'b1;
                enc_info.is_signalling = 1'b1;
            end
            CLS_QNAN: begin
                enc_sign          = 1'b0;
                enc_exp           = EXP_ONES;
                enc_man           = MAN_QUIET;
                enc_info.is_nan   = 1'b1;
                enc_info.is_quiet = 1'b1;
            end
            default: begin
                // Reserved class: produce the canonical qNaN and flag it.
                enc_sign          = 1'b0;
                enc_exp           = EXP_ONES;
                enc_man           = MAN_QUIET;
                enc_info.is_nan   = 1'b1;
                enc_info.is_quiet = 1'b1;
                enc_invalid       = 1'b1;
            end
        endcase
        enc_result             = {FLEN{BOX_BIT}};
        enc_result[WIDTH-1:0]  = {enc_sign, enc_exp, enc_man};
    end

    if (NumPipeRegs == 0) begin : g_comb
        assign in_ready_o  = out_ready_i;
        assign out_valid_o = in_valid_i;
        assign result_o    = enc_result;
        assign info_o      = enc_info;
        assign invalid_o   = enc_invalid;
        assign tag_o       = tag_i;
        assign busy_o      = 1'b0;
    end else begin : g_pipe
        localparam int unsigned N = NumPipeRegs;

        logic [N-1:0]          valid_q;
        logic [N-1:0]          ready;
        logic [FLEN-1:0]       result_q  [N];
        fpnew_pkg::fp_info_t   info_q    [N];
        logic                  invalid_q [N];
        logic [TagWidth-1:0]   tag_q     [N];

        logic                  prev_valid   [N];
        logic [FLEN-1:0]       prev_result  [N];
        fpnew_pkg::fp_info_t   prev_info    [N];
        logic                  prev_invalid [N];
        logic [TagWidth-1:0]   prev_tag     [N];

        // Stage k may load when it is empty or its contents move on this cycle.
        always_comb begin
            ready[N-1] = !valid_q[N-1] || out_ready_i;
            for (int k = int'(N) - 2; k >= 0; k--) begin
                ready[k] = !valid_q[k] || ready[k+1];
            end
        end

        // Source of each stage: the encoder for stage 0, the previous stage otherwise.
        always_comb begin
            prev_valid[0]   = in_valid_i;
            prev_result[0]  = enc_result;
            prev_info[0]    = enc_info;
            prev_invalid[0] = enc_invalid;
            prev_tag[0]     = tag_i;
            for (int k = 1; k < int'(N); k++) begin
                prev_valid[k]   = valid_q[k-1];
                prev_result[k]  = result_q[k-1];
                prev_info[k]    = info_q[k-1];
                prev_invalid[k] = invalid_q[k-1];
                prev_tag[k]     = tag_q[k-1];
            end
        end

        // Pipeline registers: flush clears valids, data only moves with a valid request.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                // NOTE: the data registers are reset as well as the valids, so the
                // outputs read as zero straight out of reset, not as stale data.
                valid_q <= '0;
                for (int k = 0; k < int'(N); k++) begin
                    result_q[k]  <= '0;
                    info_q[k]    <= '0;
                    invalid_q[k] <= 1'b0;
                    tag_q[k]     <= '0;
                end
            end else begin
                // NOTE: non-blocking assignments let every stage see the previous
                // stage's pre-edge value, so requests shift by exactly one stage.
                for (int k = 0; k < int'(N); k++) begin
                    if (flush_i) begin
                        valid_q[k] <= 1'b0;
                    end else if (ready[k]) begin
                        valid_q[k] <= prev_valid[k];
                    end
                    if (ready[k] && prev_valid[k]) begin
                        result_q[k]  <= prev_result[k];
                        info_q[k]    <= prev_info[k];
                        invalid_q[k] <= prev_invalid[k];
                        tag_q[k]     <= prev_tag[k];
                    end
                end
            end
        end

        assign in_ready_o  = ready[0];
        assign out_valid_o = valid_q[N-1];
        assign result_o    = result_q[N-1];
        assign info_o      = info_q[N-1];
        assign invalid_o   = invalid_q[N-1];
        assign tag_o       = tag_q[N-1];
        assign busy_o      = |valid_q;
    end

endmodule

// File: tb/tb_fpnew_special_encoder.sv
// Directed bench for fpnew_special_encoder: FP32, FLEN=64, with instances at
// NumPipeRegs = 1, 2 and 0 sharing clock, reset and request payload.
module tb_fpnew_special_encoder;

`ifdef FPNEW_SPECIAL_ENC_BOX_EN
    localparam logic [31:0] BOX_HI = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] BOX_HI = 32'h0000_0000;
`endif

    // Expected info byte, bit 7..0 = normal, subnormal, zero, inf, nan, signalling, quiet, boxed
    localparam logic [7:0] I_ZERO = 8'h21;
    localparam logic [7:0] I_SUB  = 8'h41;
    localparam logic [7:0] I_NORM = 8'h81;
    localparam logic [7:0] I_INF  = 8'h11;
    localparam logic [7:0] I_QNAN = 8'h0B;
    localparam logic [7:0] I_SNAN = 8'h0D;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] cls = '0;
    logic       sgn = 1'b0;
    logic [3:0] tag = '0;

    logic inv1 = 0, ordy1 = 0, fl1 = 0;
    logic inv2 = 0, ordy2 = 0, fl2 = 0;
    logic inv0 = 0, ordy0 = 0, fl0 = 0;

    logic                in_ready1, invalid1, out_valid1, busy1;
    logic [63:0]         result1;
    fpnew_pkg::fp_info_t info1;
    logic [3:0]          tag1;

    logic                in_ready2, invalid2, out_valid2, busy2;
    logic [63:0]         result2;
    fpnew_pkg::fp_info_t info2;
    logic [3:0]          tag2;

    logic                in_ready0, invalid0, out_valid0, busy0;
    logic [63:0]         result0;
    fpnew_pkg::fp_info_t info0;
    logic [3:0]          tag0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fpnew_special_encoder #(.FpFormat(fpnew_pkg::FP32), .FLEN(64), .NumPipeRegs(1), .TagWidth(4)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(fl1), .class_i(cls), .sign_i(sgn), .tag_i(tag),
        .in_valid_i(inv1), .in_ready_o(in_ready1), .result_o(result1), .info_o(info1),
        .invalid_o(invalid1), .tag_o(tag1), .out_valid_o(out_valid1), .out_ready_i(ordy1), .busy_o(busy1)
    );

    fpnew_special_encoder #(.FpFormat(fpnew_pkg::FP32), .FLEN(64), .NumPipeRegs(2), .TagWidth(4)) u_dut2 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(fl2), .class_i(cls), .sign_i(sgn), .tag_i(tag),
        .in_valid_i(inv2), .in_ready_o(in_ready2), .result_o(result2), .info_o(info2),
        .invalid_o(invalid2), .tag_o(tag2), .out_valid_o(out_valid2), .out_ready_i(ordy2), .busy_o(busy2)
    );

    fpnew_special_encoder #(.FpFormat(fpnew_pkg::FP32), .FLEN(64), .NumPipeRegs(0), .TagWidth(4)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(fl0), .class_i(cls), .sign_i(sgn), .tag_i(tag),
        .in_valid_i(inv0), .in_ready_o(in_ready0), .result_o(result0), .info_o(info0),
        .invalid_o(invalid0), .tag_o(tag0), .out_valid_o(out_valid0), .out_ready_i(ordy0), .busy_o(busy0)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [2:0]  c;
        logic        s;
        logic [31:0] lo;
        logic [7:0]  info;
        logic        inval;
    } vec_t;

    vec_t vecs[9];
    logic [3:0] got_tags[$];
    int accepts;
    int outs;
    int next_tag;

    initial begin
        vecs[0] = '{3'd0, 1'b1, 32'h8000_0000, I_ZERO, 1'b0};
        vecs[1] = '{3'd4, 1'b0, 32'h7F80_0000, I_INF,  1'b0};
        vecs[2] = '{3'd3, 1'b0, 32'h7F7F_FFFF, I_NORM, 1'b0};
        vecs[3] = '{3'd2, 1'b1, 32'h8080_0000, I_NORM, 1'b0};
        vecs[4] = '{3'd1, 1'b0, 32'h0000_0001, I_SUB,  1'b0};
        vecs[5] = '{3'd5, 1'b1, 32'h7FC0_0000, I_QNAN, 1'b0};
        vecs[6] = '{3'd6, 1'b0, 32'h7F80_0001, I_SNAN, 1'b0};
        vecs[7] = '{3'd7, 1'b0, 32'h7FC0_0000, I_QNAN, 1'b1};
        vecs[8] = '{3'd4, 1'b1, 32'hFF80_0000, I_INF,  1'b0};

        // Reset state
        #12;
        check("rst_valid", {63'd0, out_valid1}, 64'd0);
        check("rst_busy", {63'd0, busy1}, 64'd0);
        check("rst_result", result1, 64'd0);
        check("rst_tag", {60'd0, tag1}, 64'd0);
        check("rst_invalid", {63'd0, invalid1}, 64'd0);
        check("rst_busy2", {63'd0, busy2}, 64'd0);
        rst_n = 1'b1;
        next_cycle();

        // Encodings through the single-stage pipe, one per cycle
        for (int i = 0; i < 9; i++) begin
            cls = vecs[i].c; sgn = vecs[i].s; tag = 4'(i + 1);
            inv1 = 1'b1; ordy1 = 1'b1;
            #1;
            check($sformatf("enc%0d_in_ready", i), {63'd0, in_ready1}, 64'd1);
            next_cycle();
            inv1 = 1'b0;
            check($sformatf("enc%0d_valid", i), {63'd0, out_valid1}, 64'd1);
            check($sformatf("enc%0d_result", i), result1, {BOX_HI, vecs[i].lo});
            check($sformatf("enc%0d_info", i), 64'(info1), {56'd0, vecs[i].info});
            check($sformatf("enc%0d_invalid", i), {63'd0, invalid1}, {63'd0, vecs[i].inval});
            check($sformatf("enc%0d_tag", i), {60'd0, tag1}, 64'(i + 1));
        end
        next_cycle();
        check("drain_valid", {63'd0, out_valid1}, 64'd0);

        // Output stability under backpressure
        cls = 3'd4; sgn = 1'b0; tag = 4'd9; inv1 = 1'b1; ordy1 = 1'b0;
        next_cycle();
        inv1 = 1'b0; cls = 3'd0; sgn = 1'b1; tag = 4'd2;
        next_cycle();
        next_cycle();
        check("hold_valid", {63'd0, out_valid1}, 64'd1);
        check("hold_result", result1, {BOX_HI, 32'h7F80_0000});
        check("hold_tag", {60'd0, tag1}, 64'd9);
        check("hold_busy", {63'd0, busy1}, 64'd1);
        check("hold_in_ready", {63'd0, in_ready1}, 64'd0);
        ordy1 = 1'b1;
        next_cycle();
        check("release_valid", {63'd0, out_valid1}, 64'd0);

        // Two-stage pipe: backpressure, then release, ordering preserved
        accepts = 0; next_tag = 1;
        for (int c = 0; c < 20; c++) begin
            ordy2 = (c >= 4);
            inv2 = (next_tag <= 3);
            tag = 4'(next_tag);
            #1;
            if (c == 3) begin
                check("bp_in_ready_low", {63'd0, in_ready2}, 64'd0);
                check("bp_accepts", 64'(accepts), 64'd2);
            end
            if (out_valid2 && ordy2) got_tags.push_back(tag2);
            if (inv2 && in_ready2) begin
                accepts++;
                next_tag++;
            end
            next_cycle();
        end
        inv2 = 1'b0;
        check("bp_out_count", 64'(got_tags.size()), 64'd3);
        for (int i = 0; i < got_tags.size(); i++)
            check($sformatf("bp_order%0d", i), {60'd0, got_tags[i]}, 64'(i + 1));

        // Flush with two requests in flight and a same-cycle request
        ordy2 = 1'b0; inv2 = 1'b1; tag = 4'd4;
        next_cycle();
        tag = 4'd5;
        next_cycle();
        check("fl_busy_before", {63'd0, busy2}, 64'd1);
        tag = 4'd6; fl2 = 1'b1;
        next_cycle();
        fl2 = 1'b0; inv2 = 1'b0;
        check("fl_busy_after", {63'd0, busy2}, 64'd0);
        check("fl_valid_after", {63'd0, out_valid2}, 64'd0);
        ordy2 = 1'b1; outs = 0;
        for (int c = 0; c < 5; c++) begin
            if (out_valid2) outs++;
            next_cycle();
        end
        check("fl_no_outputs", 64'(outs), 64'd0);

        // Flush beats a same-cycle request into an empty stage
        cls = 3'd4; sgn = 1'b0; tag = 4'd7; inv1 = 1'b1; ordy1 = 1'b1; fl1 = 1'b1;
        #1;
        check("fl1_in_ready", {63'd0, in_ready1}, 64'd1);
        next_cycle();
        fl1 = 1'b0; inv1 = 1'b0;
        check("fl1_valid", {63'd0, out_valid1}, 64'd0);
        check("fl1_busy", {63'd0, busy1}, 64'd0);

        // Combinational pass-through
        cls = 3'd4; sgn = 1'b1; tag = 4'd5; inv0 = 1'b1; ordy0 = 1'b0;
        #1;
        check("p0_in_ready_lo", {63'd0, in_ready0}, 64'd0);
        check("p0_valid", {63'd0, out_valid0}, 64'd1);
        check("p0_result", result0, {BOX_HI, 32'hFF80_0000});
        check("p0_tag", {60'd0, tag0}, 64'd5);
        check("p0_busy", {63'd0, busy0}, 64'd0);
        ordy0 = 1'b1;
        #1;
        check("p0_in_ready_hi", {63'd0, in_ready0}, 64'd1);
        inv0 = 1'b0;
        next_cycle();

        // Asynchronous reset while a request is held at the output
        cls = 3'd7; sgn = 1'b0; tag = 4'hA; inv1 = 1'b1; ordy1 = 1'b0;
        next_cycle();
        inv1 = 1'b0;
        check("pre_rst_invalid", {63'd0, invalid1}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", {63'd0, out_valid1}, 64'd0);
        check("arst_result", result1, 64'd0);
        check("arst_tag", {60'd0, tag1}, 64'd0);
        check("arst_invalid", {63'd0, invalid1}, 64'd0);
        check("arst_busy", {63'd0, busy1}, 64'd0);
        #2;
        rst_n = 1'b1;
        next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
